// File: rtl/cond_pkg.sv
// Shared definitions for the SIMD condition unit: condition codes, flag bit
// positions inside a lane's NZCV nibble, and branch-decision modes.
package cond_pkg;

    typedef enum logic [3:0] {
        AL = 4'b0000,
        EQ = 4'b0001,
        NE = 4'b0010,
        CS = 4'b0011,
        GE = 4'b0100,
        LT = 4'b0101,
        GT = 4'b0110,
        LE = 4'b0111,
        CC = 4'b1000,
        MI = 4'b1001,
        PL = 4'b1010,
        NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int BR_LANE0 = 0;
    localparam int BR_ANY   = 1;
    localparam int BR_ALL   = 2;

endpackage

// File: rtl/cond_eval.sv
// Single-lane condition evaluator: a 4-bit condition code against one NZCV nibble.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    // Reserved encodings fall through to the default and never pass.
    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            AL:      pass_o = 1'b1;
            EQ:      pass_o = z;
            NE:      pass_o = ~z;
            CS:      pass_o = c;
            GE:      pass_o = (n == v);
            LT:      pass_o = (n != v);
            GT:      pass_o = ~z & (n == v);
            LE:      pass_o = z | (n != v);
            CC:      pass_o = ~c;
            MI:      pass_o = n;
            PL:      pass_o = ~n;
            NV:      pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit_simd.sv
// Per-lane NZCV registers with condition evaluation, lane predication, branch
// decision, an E->M predicate register and a saturating squash counter.
module cond_unit_simd
    import cond_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int BR_MODE = 0,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_e,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [3:0]           cond_e,
    input  logic [LANES-1:0]     lane_en_e,
    input  logic [4*LANES-1:0]   alu_flags,
    input  logic [1:0]           flags_write,
    input  logic                 branch_e,
    output logic                 cond_ex,
    output logic [LANES-1:0]     lane_pred_e,
    output logic                 branch_taken,
    output logic [LANES-1:0]     lane_pred_m,
    output logic                 valid_m,
    output logic [4*LANES-1:0]   flags_q,
    output logic [CNT_W-1:0]     squash_cnt
);

    logic [LANES-1:0]   lane_pass;
    logic [LANES-1:0]   commit;
    logic [4*LANES-1:0] flags_d;
    logic [LANES-1:0]   lane_pred_m_q;
    logic               valid_m_q;
    logic [CNT_W-1:0]   squash_cnt_q;
    logic [CNT_W-1:0]   squash_cnt_d;
    logic               advance;
    logic               squash_inc;
    logic               decision;

    assign advance = ~stall & ~flush;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            cond_eval u_eval (
                .cond_i  (cond_e),
                .flags_i (flags_q[4*gi +: 4]),
                .pass_o  (lane_pass[gi])
            );

            assign commit[gi] = valid_e & advance & lane_pred_e[gi];

            // N,Z and C,V are written independently so partial-flag ops keep the rest.
            assign flags_d[4*gi+2 +: 2] = (commit[gi] & flags_write[1]) ?
                                          alu_flags[4*gi+2 +: 2] : flags_q[4*gi+2 +: 2];
            assign flags_d[4*gi +: 2]   = (commit[gi] & flags_write[0]) ?
                                          alu_flags[4*gi +: 2] : flags_q[4*gi +: 2];
        end
    endgenerate

    assign lane_pred_e = lane_pass & lane_en_e & {LANES{valid_e}};
    assign cond_ex     = lane_pass[0] & valid_e;

    // ALL mode ignores disabled lanes but refuses to branch on an empty mask.
    always_comb begin
        decision = 1'b0;
        case (BR_MODE)
            BR_LANE0: decision = lane_pass[0];
            BR_ANY:   decision = |lane_pred_e;
            BR_ALL:   decision = (|lane_en_e) & (&(lane_pass | ~lane_en_e));
            default:  decision = 1'b0;
        endcase
    end

    assign branch_taken = branch_e & valid_e & ~flush & decision;

    assign squash_inc   = valid_e & advance & (lane_pred_e == '0);
    assign squash_cnt_d = (squash_inc && squash_cnt_q != {CNT_W{1'b1}}) ?
                          squash_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : squash_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q       <= '0;
            lane_pred_m_q <= '0;
            valid_m_q     <= 1'b0;
            squash_cnt_q  <= '0;
        end else begin
            flags_q      <= flags_d;
            squash_cnt_q <= squash_cnt_d;
            if (flush) begin
                lane_pred_m_q <= '0;
                valid_m_q     <= 1'b0;
            end else if (!stall) begin
                lane_pred_m_q <= lane_pred_e;
                valid_m_q     <= valid_e;
            end
        end
    end

    assign lane_pred_m = lane_pred_m_q;
    assign valid_m     = valid_m_q;
    assign squash_cnt  = squash_cnt_q;

endmodule

// File: tb/tb_cond_unit_simd.sv
// Directed bench for cond_unit_simd: encoding table, per-lane predication,
// three branch modes side by side, stall/flush handling and counter saturation.
module tb_cond_unit_simd;
    import cond_pkg::*;

    localparam int LANES = 4;
    localparam int CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 valid_e;
    logic                 stall;
    logic                 flush;
    logic [3:0]           cond_e;
    logic [LANES-1:0]     lane_en_e;
    logic [4*LANES-1:0]   alu_flags;
    logic [1:0]           flags_write;
    logic                 branch_e;

    logic                 cond_ex0, cond_ex1, cond_ex2;
    logic [LANES-1:0]     pred_e0, pred_e1, pred_e2;
    logic                 br0, br1, br2;
    logic [LANES-1:0]     pred_m0, pred_m1, pred_m2;
    logic                 valid_m0, valid_m1, valid_m2;
    logic [4*LANES-1:0]   flags0, flags1, flags2;
    logic [CNT_W-1:0]     cnt0, cnt1, cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cond_unit_simd #(.LANES(LANES), .BR_MODE(BR_LANE0), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_e(valid_e), .stall(stall), .flush(flush),
        .cond_e(cond_e), .lane_en_e(lane_en_e), .alu_flags(alu_flags),
        .flags_write(flags_write), .branch_e(branch_e),
        .cond_ex(cond_ex0), .lane_pred_e(pred_e0), .branch_taken(br0),
        .lane_pred_m(pred_m0), .valid_m(valid_m0), .flags_q(flags0), .squash_cnt(cnt0)
    );

    cond_unit_simd #(.LANES(LANES), .BR_MODE(BR_ANY), .CNT_W(CNT_W)) dut_any (
        .clk(clk), .reset(reset), .valid_e(valid_e), .stall(stall), .flush(flush),
        .cond_e(cond_e), .lane_en_e(lane_en_e), .alu_flags(alu_flags),
        .flags_write(flags_write), .branch_e(branch_e),
        .cond_ex(cond_ex1), .lane_pred_e(pred_e1), .branch_taken(br1),
        .lane_pred_m(pred_m1), .valid_m(valid_m1), .flags_q(flags1), .squash_cnt(cnt1)
    );

    cond_unit_simd #(.LANES(LANES), .BR_MODE(BR_ALL), .CNT_W(CNT_W)) dut_all (
        .clk(clk), .reset(reset), .valid_e(valid_e), .stall(stall), .flush(flush),
        .cond_e(cond_e), .lane_en_e(lane_en_e), .alu_flags(alu_flags),
        .flags_write(flags_write), .branch_e(branch_e),
        .cond_ex(cond_ex2), .lane_pred_e(pred_e2), .branch_taken(br2),
        .lane_pred_m(pred_m2), .valid_m(valid_m2), .flags_q(flags2), .squash_cnt(cnt2)
    );

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic idle();
        valid_e     = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        branch_e    = 1'b0;
        flags_write = 2'b00;
        cond_e      = AL;
        lane_en_e   = '0;
        alu_flags   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_flags(input logic [15:0] af);
        idle();
        valid_e     = 1'b1;
        cond_e      = AL;
        lane_en_e   = 4'hF;
        flags_write = 2'b11;
        alu_flags   = af;
        step();
        idle();
    endtask

    initial begin
        tbl[0]  = '{4'b1010, AL,      1'b1};
        tbl[1]  = '{4'b1010, EQ,      1'b0};
        tbl[2]  = '{4'b1010, NE,      1'b1};
        tbl[3]  = '{4'b1010, GE,      1'b0};
        tbl[4]  = '{4'b1010, LT,      1'b1};
        tbl[5]  = '{4'b1010, GT,      1'b0};
        tbl[6]  = '{4'b1010, LE,      1'b1};
        tbl[7]  = '{4'b1010, CS,      1'b1};
        tbl[8]  = '{4'b1010, CC,      1'b0};
        tbl[9]  = '{4'b1010, MI,      1'b1};
        tbl[10] = '{4'b1010, PL,      1'b0};
        tbl[11] = '{4'b1010, NV,      1'b0};
        tbl[12] = '{4'b1010, 4'b1100, 1'b0};
        tbl[13] = '{4'b0100, EQ,      1'b1};
        tbl[14] = '{4'b0100, GE,      1'b1};
        tbl[15] = '{4'b0100, GT,      1'b0};
        tbl[16] = '{4'b0100, LE,      1'b1};

        // Reset held two cycles while a full-flag AL write is presented.
        idle();
        reset       = 1'b0;
        valid_e     = 1'b1;
        lane_en_e   = 4'hF;
        flags_write = 2'b11;
        alu_flags   = 16'hFFFF;
        step();
        step();
        chk("reset_flags", 32'(flags0), 32'h0);
        chk("reset_valid_m", 32'(valid_m0), 32'h0);
        chk("reset_pred_m", 32'(pred_m0), 32'h0);
        chk("reset_cnt", 32'(cnt0), 32'h0);

        reset       = 1'b1;
        idle();
        valid_e     = 1'b1;
        lane_en_e   = 4'b0001;
        flags_write = 2'b11;
        alu_flags   = 16'h000A;
        step();
        idle();
        chk("first_write_flags", 32'(flags0), 32'h000A);
        chk("first_valid_m", 32'(valid_m0), 32'h1);
        chk("first_pred_m", 32'(pred_m0), 32'h1);

        // Encoding sweep: loads lane 0 flags when the table entry changes them.
        for (int i = 0; i < 17; i++) begin
            if (i == 0 || tbl[i].flags != tbl[i-1].flags) begin
                load_flags({12'h000, tbl[i].flags});
                chk("sweep_load", 32'(flags0[3:0]), 32'(tbl[i].flags));
            end
            @(negedge clk);
            valid_e   = 1'b1;
            cond_e    = tbl[i].cond;
            lane_en_e = 4'b0001;
            #1;
            chk($sformatf("cond_ex[f=%b c=%b]", tbl[i].flags, tbl[i].cond),
                32'(cond_ex0), 32'(tbl[i].exp));
            chk($sformatf("pred_e[f=%b c=%b]", tbl[i].flags, tbl[i].cond),
                32'(pred_e0), {31'h0, tbl[i].exp});
            idle();
        end
        chk("sweep_cnt", 32'(cnt0), 32'h0);

        // Per-lane predication: lane Z = 1,0,1,0, EQ, N/Z-only write.
        load_flags(16'h0404);
        chk("lane_load", 32'(flags0), 32'h0404);
        valid_e     = 1'b1;
        cond_e      = EQ;
        lane_en_e   = 4'hF;
        flags_write = 2'b10;
        alu_flags   = 16'hAAAA;
        branch_e    = 1'b1;
        #1;
        chk("lane_pred_e", 32'(pred_e0), 32'h5);
        chk("br_lane0", 32'(br0), 32'h1);
        chk("br_any", 32'(br1), 32'h1);
        chk("br_all_full", 32'(br2), 32'h0);
        lane_en_e = 4'b0101;
        #1;
        chk("br_all_0101", 32'(br2), 32'h1);
        lane_en_e = 4'b0000;
        #1;
        chk("br_all_none", 32'(br2), 32'h0);
        chk("br_any_none", 32'(br1), 32'h0);
        lane_en_e = 4'hF;
        step();
        chk("lane_flags", 32'(flags0), 32'h0808);
        chk("lane_pred_m", 32'(pred_m0), 32'h5);
        chk("lane_valid_m", 32'(valid_m0), 32'h1);

        // Stall holds everything even with a valid full write.
        idle();
        valid_e     = 1'b1;
        cond_e      = AL;
        lane_en_e   = 4'hF;
        flags_write = 2'b11;
        alu_flags   = 16'hFFFF;
        stall       = 1'b1;
        step();
        chk("stall_flags", 32'(flags0), 32'h0808);
        chk("stall_pred_m", 32'(pred_m0), 32'h5);
        chk("stall_valid_m", 32'(valid_m0), 32'h1);
        chk("stall_cnt", 32'(cnt0), 32'h0);

        // Flush beats stall: M stage cleared, no commit, no branch.
        flush    = 1'b1;
        branch_e = 1'b1;
        #1;
        chk("flush_br0", 32'(br0), 32'h0);
        chk("flush_br1", 32'(br1), 32'h0);
        chk("flush_br2", 32'(br2), 32'h0);
        step();
        chk("flush_valid_m", 32'(valid_m0), 32'h0);
        chk("flush_pred_m", 32'(pred_m0), 32'h0);
        chk("flush_flags", 32'(flags0), 32'h0808);
        idle();

        // Squash counter: flushed/stalled NV ignored, then saturation at 15.
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        chk("cnt_reset", 32'(cnt0), 32'h0);
        valid_e   = 1'b1;
        cond_e    = NV;
        lane_en_e = 4'hF;
        flush     = 1'b1;
        step();
        chk("cnt_flushed", 32'(cnt0), 32'h0);
        flush = 1'b0;
        stall = 1'b1;
        step();
        chk("cnt_stalled", 32'(cnt0), 32'h0);
        stall = 1'b0;
        chk("nv_pred_e", 32'(pred_e0), 32'h0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("cnt_nv%0d", k), 32'(cnt0), (k > 15) ? 32'd15 : 32'(k));
        end
        flush = 1'b1;
        step();
        chk("cnt_sat_flushed", 32'(cnt0), 32'd15);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_unit_simd.md
Name: cond_unit_simd

Overview:
Parametrised successor to the scalar condition-check unit in the execute stage of the SIMD audio pipeline. Holds one NZCV flag register per SIMD lane and evaluates the 4-bit condition field per lane to produce a lane predicate mask and a branch-taken decision. Commits flags under stall/flush control, and registers the predicate into the memory stage. A saturating counter tracks condition-squashed instructions for FIR profiling.

Parameters:
LANES, 4, number of SIMD lanes; each lane has an independent NZCV register (1..8).
BR_MODE, 0, branch decision source: 0 = lane 0 only, 1 = any enabled lane passes, 2 = all enabled lanes pass.
CNT_W, 16, width of the squash counter.

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-low reset
valid_e  in  1  execute-stage instruction valid
stall  in  1  hold all state; no flag commit, no counter update
flush  in  1  kill execute-stage instruction; no commit, predicate register cleared
cond_e  in  4  condition code of the execute-stage instruction
lane_en_e  in  LANES  lanes the instruction operates on
alu_flags  in  4*LANES  per-lane {N,Z,C,V} from the ALU; lane i at [4i+3:4i]
flags_write  in  2  [1] writes N,Z; [0] writes C,V
branch_e  in  1  instruction is a branch
cond_ex  out  1  combinational: lane-0 condition result ANDed with valid_e
lane_pred_e  out  LANES  combinational: per-lane pass AND lane_en_e AND valid_e
branch_taken  out  1  combinational: branch_e AND valid_e AND ~flush AND decision per BR_MODE
lane_pred_m  out  LANES  registered predicate for the memory stage
valid_m  out  1  registered valid for the memory stage
flags_q  out  4*LANES  current per-lane flag registers
squash_cnt  out  CNT_W  saturating count of valid, unflushed instructions with lane_pred_e all zero

Behaviour:
- Reset (reset==0 at a rising edge): flags_q=0, lane_pred_m=0, valid_m=0, squash_cnt=0. Reset has priority over stall and flush. Reset mid-instruction discards it.
- Condition encodings (evaluated against flags_q, not alu_flags):
  - 0000 AL=1, 0001 EQ=Z, 0010 NE=~Z, 0011 CS=C, 0100 GE=(N==V), 0101 LT=(N!=V)
  - 0110 GT=~Z&(N==V), 0111 LE=Z|(N!=V), 1000 CC=~C, 1001 MI=N, 1010 PL=~N
  - 1111 NV=0; all other codes are reserved and evaluate to 0.
- Commit condition for a lane: valid_e & ~stall & ~flush & lane_pred_e[i]. On commit, at the next edge, flags_q lane i N,Z take alu_flags lane i if flags_write[1], and C,V take it if flags_write[0]. Failed or disabled lanes keep their flags.
- Flags written in cycle t are visible to the condition check in cycle t+1. There is no same-cycle forwarding; back-to-back dependent instructions see the updated flags one cycle later.
- Branch decision:
  - BR_MODE 0: lane 0 pass.
  - BR_MODE 1: OR of lane_pred_e.
  - BR_MODE 2: AND over enabled lanes; if lane_en_e==0 the decision is 0.
- Pipeline register:
  - ~stall & ~flush: lane_pred_m<=lane_pred_e, valid_m<=valid_e.
  - flush (takes priority over stall): lane_pred_m<=0, valid_m<=0.
  - stall without flush: hold.
- squash_cnt: increments when valid_e & ~stall & ~flush & lane_pred_e==0. Saturates at all-ones with no wrap.
- One cycle of latency from the E stage to the M registers. All decision outputs are combinational in E.

Decomposition:
- Shared package cond_pkg:
  - condition-code enum cond_t (AL, EQ, NE, CS, GE, LT, GT, LE, CC, MI, PL, NV)
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - BR_MODE constants.
- One natural sub-module, cond_eval: purely combinational, 4-bit cond plus 4-bit flags in, 1-bit pass out. It is instantiated once per lane via a generate loop.
- Flag registers, pipeline register and counter live in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles with alu_flags all-ones and flags_write=11 -> flags_q=0, valid_m=0, squash_cnt=0. Release reset, then AL with flags_write=11 and alu_flags lane0=1010 -> flags_q lane0=1010 next cycle.
- Encoding sweep on lane 0 with flags_q lane0 = 1010:
  - AL=1, EQ=0, NE=1, GE=0, LT=1, GT=0, LE=1, CS=1, CC=0, MI=1, PL=0, NV=0, reserved 1100=0.
  - Repeat with flags 0100 (Z set): EQ=1, GE=1, GT=0, LE=1.
- Per-lane predication, LANES=4:
  - Lane flags Z=1,0,1,0; cond EQ; lane_en_e=1111; flags_write=10 -> lane_pred_e=0101.
  - Only lanes 0 and 2 update their flags.
- Branch modes, same flags, branch_e=1, cond EQ:
  - BR_MODE0 -> taken=1; BR_MODE1 -> 1; BR_MODE2 -> 0.
  - BR_MODE2 with lane_en_e=0101 -> 1; with lane_en_e=0000 -> 0.
- Stall/flush:
  - stall=1 with a valid AL write -> flags_q, lane_pred_m and squash_cnt unchanged.
  - stall=1 and flush=1 together -> valid_m=0, lane_pred_m=0, flags unchanged, branch_taken=0.
- Counter saturation, CNT_W=4:
  - 20 valid NV instructions -> squash_cnt climbs to 15 and holds.
  - A flushed NV instruction does not count.
